// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  typedef struct packed {
    logic [29:0] index;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        is_write;
  } dmem_req_t;
endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) seeded on reset
module lfsr8
  import dmem_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Enable,
  output logic [7:0] Value
);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) Value <= LFSR_SEED;
    else if (Enable) Value <= (Value >> 1) ^ (Value[0] ? LFSR_TAPS : 8'h00);
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: word RAM answering held-high D-mem requests after LATENCY cycles
// DMEM_STALL_INJECT_EN adds 0..3 pseudo-random extra cycles per transaction.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DataMemReadEnable,
  input  logic        DataMemWriteEnable,
  input  logic [31:0] DataMemAddress,
  input  logic [31:0] WriteData,
  input  logic [3:0]  DataMemByteEnable,
  output logic        DataMemAck,
  output logic [31:0] ReadDataOriginal,
  output logic        Busy
);
  dmem_state_e state, nxt;
  logic [4:0] cnt, cnt_nxt, first;
  dmem_req_t req, cur;
  logic go;
  logic [31:0] mem [DEPTH];
`ifdef DMEM_STALL_INJECT_EN
  logic [7:0] lfsr_val;
  logic unused_lfsr;
  lfsr8 u_lfsr (.CLK(CLK), .RST_N(RST_N), .Enable(1'b1), .Value(lfsr_val));
  assign first = 5'(LATENCY - 1) + 5'(lfsr_val[1:0]);
  assign unused_lfsr = ^lfsr_val[7:2];
`else
  assign first = 5'(LATENCY - 1);
`endif
  // In IDLE the live inputs act as the request so LATENCY=1 can respond without a latch cycle
  always_comb begin
    cur = (state == IDLE) ? dmem_req_t'{index: DataMemAddress[31:2], wdata: WriteData,
                                        be: DataMemByteEnable, is_write: DataMemWriteEnable} : req;
    nxt = state;
    cnt_nxt = cnt;
    if (state == IDLE && (DataMemReadEnable || DataMemWriteEnable)) begin
      nxt = (first == 5'd0) ? RESP : WAIT;
      cnt_nxt = first;
    end else if (state == WAIT) begin
      nxt = (cnt == 5'd1) ? RESP : WAIT;
      cnt_nxt = cnt - 5'd1;
    end else if (state == RESP) nxt = IDLE;
  end
  assign go = (nxt == RESP) && (state != RESP);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      cnt <= '0;
      req <= '0;
      ReadDataOriginal <= '0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      if (state == IDLE) req <= cur;
      if (go && !cur.is_write) ReadDataOriginal <= mem[cur.index[AW-1:0]];
    end
  always_ff @(posedge CLK)
    if (go && cur.is_write)
      for (int i = 0; i < 4; i++)
        if (cur.be[i]) mem[cur.index[AW-1:0]][8*i +: 8] <= cur.wdata[8*i +: 8];
  logic unused_addr;
  assign unused_addr = ^{DataMemAddress[1:0], cur.index};
  assign DataMemAck = (state == RESP);
  assign Busy = (state != IDLE);
endmodule
